alu_result_capture: RTL and testbench
=====================================

// Module: alu_result_capture
// PURPOSE
//  Consumer end of the ALU interface: registers each ALU result plus its flags into a small response FIFO.
//  Returns the captured records to the datapath or sequencer with a valid/ready handshake.
//  Sits directly after alu; the producer presents {op, result, flags} and the consumer drains responses.
//  Qualifies the raw ALU flags per opcode, so the consumer sees only architecturally meaningful flags.
// PARAMETERS
//  DEPTH     4   FIFO entries, power of two, >=2
//  CNT_W     16  width of the overflow event counter (sticky feature only)
// PORTS
//  CLOCK_50     in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  cap_valid    in   1      producer presents a valid ALU record
//  cap_ready    out  1      FIFO can accept; equals !full
//  cap_op       in   4      ALU_OP that produced the record
//  alu_result   in   32     ALU result
//  zero         in   1      ALU zero flag
//  overflow     in   1      ALU signed overflow flag
//  lessthan     in   1      ALU less-than flag
//  carry        in   1      ALU carry flag
//  rsp_valid    out  1      head record available
//  rsp_ready    in   1      consumer takes the head record
//  rsp_op       out  4      head opcode
//  rsp_result   out  32     head result
//  rsp_flags    out  5      {illegal, carry, lessthan, overflow, zero}
//  level        out  $clog2(DEPTH)+1  current occupancy
//  status_clr   in   1      clear sticky status (sticky feature)
//  sticky_ovf   out  1      an overflow has been captured since the last clear
//  sticky_carry out  1      a carry has been captured since the last clear
//  ovf_count    out  CNT_W  saturating count of captured overflows
// BEHAVIOUR
//  Reset (async): rd/wr pointers=0, level=0, rsp_valid=0, rsp_op/result/flags=0, all sticky outputs=0.
//  Push when cap_valid&&cap_ready. Pop when rsp_valid&&rsp_ready. Handshake outputs have no combinational input->output path.
//  Latency: a record accepted at edge N is visible on rsp_* after edge N (rsp_valid=1 in cycle N+1). No bypass.
//  Outputs are taken from the head entry. rsp_* holds stable while rsp_valid=1 and rsp_ready=0.
//  Push and pop in the same cycle, non-empty: level is unchanged and both pointers advance.
//  Full: cap_ready=0, even if rsp_ready=1 in that cycle. The producer must hold its record.
//  Empty: rsp_valid=0 and pops are ignored. Pointers wrap modulo DEPTH; level counts 0..DEPTH.
//  Flag qualification, applied at push:
//   - overflow kept only for ADD(0010) and SUB(0011); otherwise stored as 0.
//   - carry kept only for ADD, SUB, SUBU(1001) and ADDU(1011); otherwise stored as 0.
//   - zero and lessthan are stored as presented.
//   - illegal=1 for op 1010 or 11xx; the record is still stored.
//  Reset mid-operation discards all entries immediately; no partial handshake survives.
// CONFIGURATION
//  Macro ALU_STICKY_STATUS_EN.
//  Defined:
//   - sticky_ovf and sticky_carry set on a push whose qualified flag is 1.
//   - ovf_count increments on such pushes and saturates at all-ones.
//   - status_clr zeroes all three. A qualified event in the same cycle as status_clr wins: result is 1 / count=1.
//  Undefined: sticky_ovf, sticky_carry and ovf_count are driven constant 0; status_clr is ignored. The ports remain.
// STRUCTURE
//  Shared package alu_pkg:
//   - ALU_OP localparams: AND=0000 OR=0001 ADD=0010 SUB=0011 NOR=0100 XOR=0101 SLT=0110
//     SLL=0111 SRL=1000 SUBU=1001 ADDU=1011.
//   - Flag bit indices: Z=0 V=1 LT=2 C=3 ILL=4.
//   - Record width localparam REC_W=41.
//  One sub-module: alu_rec_fifo, a generic DEPTH x REC_W synchronous FIFO with level output.
//  The top level holds flag qualification and sticky logic.
// TESTING
//  1. After reset, push rs=7,rt=5 results for AND/OR/ADD/SUB (5/7/12/2).
//     -> rsp_result 5,7,12,2 in order; flags zero=0; rsp_valid rises one cycle after the first push.
//  2. ADD of 0x7FFFFFFF+1, alu_result=0x80000000, overflow=1.
//     -> rsp_flags[1]=1; the same raw overflow on XOR -> stored 0.
//  3. Push 4 records with rsp_ready=0.
//     -> level=4, cap_ready=0; 5th record held; one pop -> cap_ready=1 next cycle; FIFO order preserved.
//  4. Continuous push+pop at level=2 for 10 cycles.
//     -> level stays 2; pointer wrap gives no loss or duplication.
//  5. Push op=1010 and op=1100.
//     -> rsp_flags[4]=1 and the record is returned.
//  6. ALU_STICKY_STATUS_EN: 3 ADD overflows -> ovf_count=3, sticky_ovf=1.
//     status_clr together with a 4th overflow -> sticky_ovf=1, ovf_count=1.
//     Macro undefined: all sticky outputs remain 0.
//  7. Assert reset with level=3.
//     -> level=0, rsp_valid=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions, the captured record
// layout and the per-opcode flag qualification helper.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SLT  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SUBU = 4'b1001;
    localparam logic [3:0] ALU_ADDU = 4'b1011;

    localparam int FLAG_Z   = 0;
    localparam int FLAG_V   = 1;
    localparam int FLAG_LT  = 2;
    localparam int FLAG_C   = 3;
    localparam int FLAG_ILL = 4;

    localparam int FLAGS_W = 5;
    localparam int REC_W   = 41;

    typedef struct packed {
        logic [3:0]         op;
        logic [31:0]        result;
        logic [FLAGS_W-1:0] flags;
    } alu_rec_t;

    // Opcode 1010 and the whole 11xx range have no defined ALU operation.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op == 4'b1010) || (op[3:2] == 2'b11);
    endfunction

    // Keep only the flags that carry architectural meaning for this opcode.
    function automatic logic [FLAGS_W-1:0] qualify_flags(
        input logic [3:0] op,
        input logic       zero,
        input logic       overflow,
        input logic       lessthan,
        input logic       carry
    );
        logic [FLAGS_W-1:0] f;
        f           = 5'b00000;
        f[FLAG_Z]   = zero;
        f[FLAG_LT]  = lessthan;
        f[FLAG_V]   = overflow && ((op == ALU_ADD) || (op == ALU_SUB));
        f[FLAG_C]   = carry && ((op == ALU_ADD) || (op == ALU_SUB) ||
                                (op == ALU_SUBU) || (op == ALU_ADDU));
        f[FLAG_ILL] = is_illegal_op(op);
        return f;
    endfunction

endpackage

// File: rtl/alu_rec_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with occupancy output.
// The head entry is held in an output register so the read side has no
// combinational path from any input; a record written at edge N is visible
// on pop_data right after edge N.
module alu_rec_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 41,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] count_r;
    logic [WIDTH-1:0] head_r;
    logic             valid_r;

    logic             push_s;
    logic             pop_s;
    logic [PTR_W-1:0] wr_next_s;
    logic [PTR_W-1:0] rd_next_s;
    logic [LVL_W-1:0] count_next_s;
    logic [WIDTH-1:0] head_next_s;

    assign push_ready = (count_r != LVL_W'(DEPTH));
    assign push_s     = push_valid && push_ready;
    assign pop_s      = valid_r && pop_ready;
    assign pop_valid  = valid_r;
    assign pop_data   = head_r;
    assign level      = count_r;

    // Next pointers, occupancy and the record that will sit at the head.
    always_comb begin
        wr_next_s    = push_s ? (wr_ptr_r + PTR_W'(1)) : wr_ptr_r;
        rd_next_s    = pop_s  ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + LVL_W'(1);
            2'b01:   count_next_s = count_r - LVL_W'(1);
            default: count_next_s = count_r;
        endcase
        if (count_next_s == LVL_W'(0)) begin
            head_next_s = head_r;
        end else if (push_s && (rd_next_s == wr_ptr_r)) begin
            // New head is the slot being written this cycle.
            head_next_s = push_data;
        end else begin
            head_next_s = mem_r[rd_next_s];
        end
    end

    // Storage, pointers, occupancy and registered head/valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            head_r   <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
            end
            wr_ptr_r <= wr_next_s;
            rd_ptr_r <= rd_next_s;
            count_r  <= count_next_s;
            head_r   <= head_next_s;
            valid_r  <= (count_next_s != LVL_W'(0));
        end
    end

endmodule

// File: rtl/alu_result_capture.sv
// Consumer end of the ALU interface. Qualifies the raw ALU flags per opcode,
// stores {op, result, flags} in a small response FIFO and returns records
// through a valid/ready handshake.
// Optional feature: define ALU_STICKY_STATUS_EN to enable the sticky
// overflow/carry status bits and the saturating overflow event counter.
module alu_result_capture
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     cap_valid,
    output logic                     cap_ready,
    input  logic [3:0]               cap_op,
    input  logic [31:0]              alu_result,
    input  logic                     zero,
    input  logic                     overflow,
    input  logic                     lessthan,
    input  logic                     carry,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [3:0]               rsp_op,
    output logic [31:0]              rsp_result,
    output logic [4:0]               rsp_flags,
    output logic [$clog2(DEPTH):0]   level,
    input  logic                     status_clr,
    output logic                     sticky_ovf,
    output logic                     sticky_carry,
    output logic [CNT_W-1:0]         ovf_count
);

    alu_rec_t cap_rec_s;
    alu_rec_t rsp_rec_s;
    logic     push_s;

    // Build the record to store, with flags already qualified.
    always_comb begin
        cap_rec_s.op     = cap_op;
        cap_rec_s.result = alu_result;
        cap_rec_s.flags  = qualify_flags(cap_op, zero, overflow, lessthan, carry);
    end

    assign push_s = cap_valid && cap_ready;

    alu_rec_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk        (CLOCK_50),
        .rst        (reset),
        .push_valid (cap_valid),
        .push_ready (cap_ready),
        .push_data  (cap_rec_s),
        .pop_valid  (rsp_valid),
        .pop_ready  (rsp_ready),
        .pop_data   (rsp_rec_s),
        .level      (level)
    );

    assign rsp_op     = rsp_rec_s.op;
    assign rsp_result = rsp_rec_s.result;
    assign rsp_flags  = rsp_rec_s.flags;

`ifdef ALU_STICKY_STATUS_EN
    logic             sticky_ovf_r;
    logic             sticky_carry_r;
    logic [CNT_W-1:0] ovf_count_r;
    logic             ovf_evt_s;
    logic             carry_evt_s;

    assign ovf_evt_s   = push_s && cap_rec_s.flags[FLAG_V];
    assign carry_evt_s = push_s && cap_rec_s.flags[FLAG_C];

    // Sticky status; an event coinciding with a clear survives the clear.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sticky_ovf_r   <= 1'b0;
            sticky_carry_r <= 1'b0;
            ovf_count_r    <= '0;
        end else if (status_clr) begin
            sticky_ovf_r   <= ovf_evt_s;
            sticky_carry_r <= carry_evt_s;
            ovf_count_r    <= ovf_evt_s ? CNT_W'(1) : CNT_W'(0);
        end else begin
            if (ovf_evt_s) begin
                sticky_ovf_r <= 1'b1;
            end
            if (carry_evt_s) begin
                sticky_carry_r <= 1'b1;
            end
            if (ovf_evt_s && (ovf_count_r != {CNT_W{1'b1}})) begin
                ovf_count_r <= ovf_count_r + CNT_W'(1);
            end
        end
    end

    assign sticky_ovf   = sticky_ovf_r;
    assign sticky_carry = sticky_carry_r;
    assign ovf_count    = ovf_count_r;
`else
    logic unused_status_s;
    assign unused_status_s = status_clr ^ push_s;
    assign sticky_ovf      = 1'b0;
    assign sticky_carry    = 1'b0;
    assign ovf_count       = '0;
`endif

endmodule

// File: tb/tb_alu_result_capture.sv
// Scoreboard bench for alu_result_capture: every accepted record is pushed
// with its expected qualified flags and compared when the DUT hands it out.
module tb_alu_result_capture;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        cap_valid;
    logic        cap_ready;
    logic [3:0]  cap_op;
    logic [31:0] alu_result;
    logic        zero, overflow, lessthan, carry;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_op;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic [2:0]  level;
    logic        status_clr;
    logic        sticky_ovf;
    logic        sticky_carry;
    logic [15:0] ovf_count;

    int checks = 0;
    int errors = 0;
    logic [40:0] sb_q [$];

    alu_result_capture #(.DEPTH(4), .CNT_W(16)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .cap_valid    (cap_valid),
        .cap_ready    (cap_ready),
        .cap_op       (cap_op),
        .alu_result   (alu_result),
        .zero         (zero),
        .overflow     (overflow),
        .lessthan     (lessthan),
        .carry        (carry),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_op       (rsp_op),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .level        (level),
        .status_clr   (status_clr),
        .sticky_ovf   (sticky_ovf),
        .sticky_carry (sticky_carry),
        .ovf_count    (ovf_count)
    );

    // Free-running 100 MHz-style clock.
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference flag qualification, written from the opcode table.
    function automatic logic [4:0] exp_flags(input logic [3:0] op, input logic z, v, lt, c);
        logic ill, vq, cq;
        ill = (op == 4'b1010) || (op == 4'b1100) || (op == 4'b1101) ||
              (op == 4'b1110) || (op == 4'b1111);
        vq  = v && ((op == 4'b0010) || (op == 4'b0011));
        cq  = c && ((op == 4'b0010) || (op == 4'b0011) || (op == 4'b1001) || (op == 4'b1011));
        return {ill, cq, lt, vq, z};
    endfunction

    // Scoreboard: compare handed-out records, then log newly accepted ones.
    always @(negedge CLOCK_50) begin
        if (!reset) begin
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected", 64'(sb_q.size()), 64'd1);
                end else begin
                    check_eq("sb_record", {23'd0, rsp_op, rsp_result, rsp_flags}, {23'd0, sb_q[0]});
                    void'(sb_q.pop_front());
                end
            end
            if (cap_valid && cap_ready) begin
                sb_q.push_back({cap_op, alu_result, exp_flags(cap_op, zero, overflow, lessthan, carry)});
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] res,
                         input logic z, input logic v, input logic lt, input logic c);
        logic got;
        cap_op = op; alu_result = res; zero = z; overflow = v; lessthan = lt; carry = c;
        cap_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge CLOCK_50);
            got = cap_ready;
        end
        check_eq("push_accept", 64'(got), 64'd1);
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 50 && level != 3'd0; i++) begin
            tick();
        end
        check_eq("drain_level", 64'(level), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cap_valid = 1'b0; cap_op = 4'd0; alu_result = 32'd0;
        zero = 1'b0; overflow = 1'b0; lessthan = 1'b0; carry = 1'b0;
        rsp_ready = 1'b0; status_clr = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check_eq("rst_level",  64'(level), 64'd0);
        check_eq("rst_valid",  64'(rsp_valid), 64'd0);
        check_eq("rst_ready",  64'(cap_ready), 64'd1);
        check_eq("rst_rsp",    {27'd0, rsp_op, rsp_result, rsp_flags}, 64'd0);
        check_eq("rst_sticky", {46'd0, sticky_ovf, sticky_carry, ovf_count}, 64'd0);

        // 1. Basic results in order, latency of one edge
        rsp_ready = 1'b1;
        drive(4'b0000, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("lat_valid", 64'(rsp_valid), 64'd1);
        drive(4'b0001, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(4'b0010, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(4'b0011, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // 2. Overflow qualification
        rsp_ready = 1'b0;
        drive(4'b0010, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("add_ovf", 64'(rsp_flags[1]), 64'd1);
        drive(4'b0101, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        rsp_ready = 1'b1;
        tick();
        check_eq("xor_ovf", 64'(rsp_flags[1]), 64'd0);
        check_eq("xor_carry", 64'(rsp_flags[3]), 64'd0);
        drive(4'b1001, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(4'b0000, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();

        // 3. Full FIFO holds the producer, one pop frees a slot
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(4'b0001, 32'(100 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("full_level", 64'(level), 64'd4);
        check_eq("full_ready", 64'(cap_ready), 64'd0);
        cap_op = 4'b0001; alu_result = 32'd104; cap_valid = 1'b1;
        tick(); tick();
        check_eq("full_hold_level", 64'(level), 64'd4);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check_eq("after_pop_ready", 64'(cap_ready), 64'd1);
        check_eq("after_pop_level", 64'(level), 64'd3);
        tick();
        cap_valid = 1'b0;
        check_eq("refill_level", 64'(level), 64'd4);
        drain();

        // 4. Sustained push+pop at level 2 across pointer wrap
        rsp_ready = 1'b0;
        drive(4'b0101, 32'd200, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(4'b0101, 32'd201, 1'b0, 1'b0, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(4'b0110, 32'(300 + i), 1'(i[0]), 1'b0, 1'(i[1]), 1'b0);
            check_eq("stream_level", 64'(level), 64'd2);
        end
        drain();

        // 5. Illegal opcodes are flagged but kept
        rsp_ready = 1'b0;
        drive(4'b1010, 32'hDEAD_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("ill_1010", 64'(rsp_flags[4]), 64'd1);
        drive(4'b1100, 32'hDEAD_0002, 1'b0, 1'b1, 1'b0, 1'b1);
        drain();

        // 6. Sticky status
        rsp_ready = 1'b1;
        status_clr = 1'b1;
        tick();
        status_clr = 1'b0;
        for (int i = 0; i < 3; i++) drive(4'b0010, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef ALU_STICKY_STATUS_EN
        check_eq("stk_count3", 64'(ovf_count), 64'd3);
        check_eq("stk_ovf", 64'(sticky_ovf), 64'd1);
        check_eq("stk_carry", 64'(sticky_carry), 64'd1);
        status_clr = 1'b1;
        drive(4'b0010, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
        status_clr = 1'b0;
        check_eq("stk_clr_ovf", 64'(sticky_ovf), 64'd1);
        check_eq("stk_clr_count", 64'(ovf_count), 64'd1);
        check_eq("stk_clr_carry", 64'(sticky_carry), 64'd0);
`else
        check_eq("stk_off", {46'd0, sticky_ovf, sticky_carry, ovf_count}, 64'd0);
`endif
        drain();

        // 7. Asynchronous reset mid-operation
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive(4'b0000, 32'(500 + i), 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("pre_rst_level", 64'(level), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_level", 64'(level), 64'd0);
        check_eq("async_valid", 64'(rsp_valid), 64'd0);
        sb_q.delete();
        tick();
        reset = 1'b0;
        tick();
        check_eq("post_rst_level", 64'(level), 64'd0);
        rsp_ready = 1'b1;
        drive(4'b0011, 32'd42, 1'b1, 1'b0, 1'b1, 1'b0);
        drain();
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
